// File: rtl/wire_stim_seq_pkg.sv
// -----------------------------------------------------------------------------
// wire_stim_seq_pkg
// Shared definitions for the wireTest2 stimulus sequencer: FSM state encoding,
// number of pattern steps and the {W,X} drive value of each step.
// No ports (package).
// -----------------------------------------------------------------------------
package wire_stim_seq_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFinish = 2'd2
    } state_e;

    localparam int unsigned NSTEPS = 5;
    localparam int unsigned STEP_W = 3;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NSTEPS - 1);

    // {W,X} drive per step: 00 -> 10 -> 11 -> 01 -> 00
    localparam logic [1:0] WX_STEP0 = 2'b00;
    localparam logic [1:0] WX_STEP1 = 2'b10;
    localparam logic [1:0] WX_STEP2 = 2'b11;
    localparam logic [1:0] WX_STEP3 = 2'b01;
    localparam logic [1:0] WX_STEP4 = 2'b00;
    localparam logic [1:0] WX_OFF   = 2'b00;

endpackage

// File: rtl/wire_stim_seq_pattern.sv
// -----------------------------------------------------------------------------
// wire_stim_seq_pattern
// Combinational decode of a pattern step index into the {W,X} drive value.
// Ports:
//   i_step  step index 0..4 (other codes decode to 00)
//   o_wx    {W,X} drive value for that step
// -----------------------------------------------------------------------------
module wire_stim_seq_pattern
    import wire_stim_seq_pkg::*;
(
    input  logic [STEP_W-1:0] i_step,
    output logic [1:0]        o_wx
);

    always_comb begin
        o_wx = WX_OFF;
        case (i_step)
            3'd0:    o_wx = WX_STEP0;
            3'd1:    o_wx = WX_STEP1;
            3'd2:    o_wx = WX_STEP2;
            3'd3:    o_wx = WX_STEP3;
            3'd4:    o_wx = WX_STEP4;
            default: o_wx = WX_OFF;
        endcase
    end

endmodule

// File: rtl/wire_stim_seq.sv
// -----------------------------------------------------------------------------
// wire_stim_seq
// Clocked, restartable stimulus sequencer for the wireTest2 unit. Walks W/X
// through 00,10,11,01,00 holding each step DWELL cycles, samples {Y,Z} once
// per step, logs it, counts mismatches against exp_yz and reports pass.
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           run request, only honoured in IDLE
//   w_out, x_out    registered drive to wireTest2 W/X
//   y_in, z_in      wireTest2 Y/Z
//   exp_yz          expected {Y,Z} per step, step k at [2k+1:2k]
//   busy            high in RUN and FINISH
//   done            one-cycle pulse in FINISH
//   yz_log          sampled {Y,Z} per step, same packing as exp_yz
//   err_cnt         number of mismatching steps of the current/last run
//   pass            last completed run had no mismatches
// -----------------------------------------------------------------------------
module wire_stim_seq #(
    parameter int unsigned DWELL = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       w_out,
    output logic       x_out,
    input  logic       y_in,
    input  logic       z_in,
    input  logic [9:0] exp_yz,
    output logic       busy,
    output logic       done,
    output logic [9:0] yz_log,
    output logic [2:0] err_cnt,
    output logic       pass
);

    import wire_stim_seq_pkg::*;

    if (DWELL < 2) begin : g_bad_dwell
        $error("wire_stim_seq: DWELL must be 2 or more");
    end

    localparam int unsigned CNT_W = (DWELL < 2) ? 1 : $clog2(DWELL);
    // Sample one edge before the step boundary so the final step's sample
    // lands at E0+5*DWELL-1 and FINISH fills the last cycle of step 4.
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(DWELL - 2);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);

    state_e            r_state;
    logic [STEP_W-1:0] r_step;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_wx;
    logic              r_busy;
    logic              r_done;
    logic [9:0]        r_yz_log;
    logic [2:0]        r_err_cnt;
    logic              r_pass;

    logic [STEP_W-1:0] w_step_next;
    logic [1:0]        w_wx_next;
    logic [1:0]        w_yz;
    logic [1:0]        w_exp_step;
    logic [9:0]        w_yz_log_next;
    logic              w_mismatch;

    assign w_step_next = r_step + 3'd1;
    assign w_yz        = {y_in, z_in};
    assign w_mismatch  = (w_yz != w_exp_step);

    wire_stim_seq_pattern u_pattern (
        .i_step (w_step_next),
        .o_wx   (w_wx_next)
    );

    // Select the expected pair for the current step and splice the sample
    // into its slot of the log.
    always_comb begin
        w_exp_step    = 2'b00;
        w_yz_log_next = r_yz_log;
        case (r_step)
            3'd0: begin
                w_exp_step         = exp_yz[1:0];
                w_yz_log_next[1:0] = w_yz;
            end
            3'd1: begin
                w_exp_step         = exp_yz[3:2];
                w_yz_log_next[3:2] = w_yz;
            end
            3'd2: begin
                w_exp_step         = exp_yz[5:4];
                w_yz_log_next[5:4] = w_yz;
            end
            3'd3: begin
                w_exp_step         = exp_yz[7:6];
                w_yz_log_next[7:6] = w_yz;
            end
            3'd4: begin
                w_exp_step         = exp_yz[9:8];
                w_yz_log_next[9:8] = w_yz;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_step    <= '0;
            r_cnt     <= '0;
            r_wx      <= WX_OFF;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_yz_log  <= '0;
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_wx <= WX_OFF;
                    if (start) begin
                        r_state   <= StRun;
                        r_busy    <= 1'b1;
                        r_step    <= '0;
                        r_cnt     <= '0;
                        r_wx      <= WX_STEP0;
                        r_yz_log  <= '0;
                        r_err_cnt <= '0;
                        r_pass    <= 1'b0;
                    end
                end
                StRun: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_SAMPLE) begin
                        r_yz_log  <= w_yz_log_next;
                        r_err_cnt <= r_err_cnt + {2'b00, w_mismatch};
                        if (r_step == STEP_LAST) begin
                            r_state <= StFinish;
                            r_done  <= 1'b1;
                            r_wx    <= WX_OFF;
                            r_pass  <= (r_err_cnt == 3'd0) && !w_mismatch;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_step <= w_step_next;
                        r_cnt  <= '0;
                        r_wx   <= w_wx_next;
                    end
                end
                StFinish: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_wx    <= WX_OFF;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_wx    <= WX_OFF;
                end
            endcase
        end
    end

    assign w_out   = r_wx[1];
    assign x_out   = r_wx[0];
    assign busy    = r_busy;
    assign done    = r_done;
    assign yz_log  = r_yz_log;
    assign err_cnt = r_err_cnt;
    assign pass    = r_pass;

endmodule

// File: tb/tb_wire_stim_seq.sv
// -----------------------------------------------------------------------------
// tb_wire_stim_seq
// Self-checking bench for wire_stim_seq with DWELL=4. Y/Z loop back from W/X,
// optionally with Z stuck at 0. Inputs driven and outputs sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_wire_stim_seq;

    localparam int unsigned D = 4;

    typedef struct {
        logic [9:0] exp_yz;
        bit         z_stuck;
        logic [9:0] log_exp;
        logic [2:0] err_exp;
        bit         pass_exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       w_out;
    logic       x_out;
    logic       y_in;
    logic       z_in;
    logic [9:0] exp_yz;
    logic       busy;
    logic       done;
    logic [9:0] yz_log;
    logic [2:0] err_cnt;
    logic       pass;
    bit         z_stuck;

    int n_vec;
    int n_err;

    logic [1:0] pat_tab [5];
    vec_t       vecs [5];

    assign y_in = w_out;
    assign z_in = z_stuck ? 1'b0 : x_out;

    wire_stim_seq #(.DWELL(D)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .w_out   (w_out),
        .x_out   (x_out),
        .y_in    (y_in),
        .z_in    (z_in),
        .exp_yz  (exp_yz),
        .busy    (busy),
        .done    (done),
        .yz_log  (yz_log),
        .err_cnt (err_cnt),
        .pass    (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Starts at a falling edge; E0 is the next rising edge. Ends at the
    // falling edge of the first IDLE cycle after the run (j = 5*D).
    task automatic run_vec(input vec_t v, input bit keep_start, input int restart_at);
        logic [1:0] wx_req;
        exp_yz  = v.exp_yz;
        z_stuck = v.z_stuck;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep_start) start = 1'b0;
        chk("clear_on_start", {22'd0, yz_log, err_cnt, pass}, 32'd0);
        for (int j = 0; j <= 5 * D; j++) begin
            if (j == restart_at) start = 1'b1;
            if (j == restart_at + 1 && !keep_start) start = 1'b0;
            wx_req = (j < 5 * D - 1) ? pat_tab[j / D] : 2'b00;
            chk($sformatf("seq_j%0d", j), {28'd0, busy, done, w_out, x_out},
                {28'd0, (j < 5 * D) ? 1'b1 : 1'b0, (j == 5 * D - 1) ? 1'b1 : 1'b0, wx_req});
            if (j < 5 * D) @(negedge clk);
        end
        chk("yz_log", {22'd0, yz_log}, {22'd0, v.log_exp});
        chk("err_cnt", {29'd0, err_cnt}, {29'd0, v.err_exp});
        chk("pass", {31'd0, pass}, {31'd0, v.pass_exp});
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        pat_tab = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        vecs[0] = '{exp_yz: 10'h078, z_stuck: 1'b0, log_exp: 10'h078, err_exp: 3'd0, pass_exp: 1'b1};
        vecs[1] = '{exp_yz: 10'h078, z_stuck: 1'b1, log_exp: 10'h028, err_exp: 3'd2, pass_exp: 1'b0};
        vecs[2] = '{exp_yz: 10'h028, z_stuck: 1'b1, log_exp: 10'h028, err_exp: 3'd0, pass_exp: 1'b1};
        vecs[3] = '{exp_yz: 10'h000, z_stuck: 1'b0, log_exp: 10'h078, err_exp: 3'd3, pass_exp: 1'b0};
        vecs[4] = '{exp_yz: 10'h3FF, z_stuck: 1'b1, log_exp: 10'h028, err_exp: 3'd5, pass_exp: 1'b0};

        // Reset held with start high
        rst_n   = 1'b0;
        start   = 1'b1;
        exp_yz  = 10'h078;
        z_stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {14'd0, w_out, x_out, busy, done, yz_log, err_cnt, pass}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_reset_idle", {14'd0, w_out, x_out, busy, done, yz_log, err_cnt, pass}, 32'd0);

        // Table of single runs
        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0, -1);

        // start pulsed at E0+7 while busy: ignored, single done
        run_vec(vecs[0], 1'b0, 6);
        repeat (2) @(negedge clk);
        chk("no_queued_restart", {31'd0, busy}, 32'd0);

        // Reset mid-run at E0+10
        exp_yz  = 10'h078;
        z_stuck = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_now", {14'd0, w_out, x_out, busy, done, yz_log, err_cnt, pass}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("midrun_reset_hold", {14'd0, w_out, x_out, busy, done, yz_log, err_cnt, pass}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], 1'b0, -1);

        // Back-to-back with start held: pass goes 1 -> 0 -> 1
        run_vec(vecs[0], 1'b1, -1);
        run_vec(vecs[3], 1'b1, -1);
        run_vec(vecs[0], 1'b1, -1);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_end_idle", {31'd0, busy}, 32'd0);
        chk("b2b_hold_log", {22'd0, yz_log}, 32'h078);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
